dmem_waitstate: RTL and testbench

//  Parametrised byte-addressed data memory for the MIPS-Lite MEM stage. Supports

---
 rtl/dmem_waitstate_if.sv | 25 ++
 rtl/dmem_waitstate.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dmem_waitstate.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_waitstate_if.sv
// Bus interface for dmem_waitstate.
// master: the requester (MEM stage or testbench) drives req/we/size/sign_ext/addr/wd.
// slave : the memory returns rd/ready/busy/err.
interface dmem_waitstate_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, we, size, sign_ext, addr, wd,
        input  rd, ready, busy, err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wd,
        output rd, ready, busy, err
    );
endinterface

// File: rtl/dmem_waitstate.sv
// dmem_waitstate: byte-addressed little-endian data memory with wait states.
// Byte/half/word accesses with sign or zero extension on reads. A request is
// accepted only in IDLE; the access is performed LATENCY cycles later and
// signalled by a one-cycle ready pulse. Misaligned, out-of-range and
// illegal-size requests skip the memory and respond one cycle after accept
// with err=1.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (memory contents are kept)
//   bus  - slave side of dmem_waitstate_if (req/we/size/sign_ext/addr/wd in,
//          rd/ready/busy/err out, all outputs registered)
module dmem_waitstate #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_waitstate_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH_BYTES);
    localparam int         RW       = (AW > 2) ? AW - 2 : 1;
    localparam int         ROWS     = DEPTH_BYTES / 4;
    localparam bit         LAT_ZERO = (LATENCY == 0);
    localparam logic [3:0] LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        do_acc;

    // Fields of the access being performed. With LATENCY=0 the access happens
    // on the accept edge itself, so the live bus inputs are used in IDLE.
    logic        a_we;
    logic [1:0]  a_size;
    logic        a_sext;
    logic [31:0] a_addr;
    logic [31:0] a_wd;

    always_comb begin
        a_we   = we_q;
        a_size = size_q;
        a_sext = sext_q;
        a_addr = addr_q;
        a_wd   = wd_q;
        if (state_q == S_IDLE) begin
            a_we   = bus.we;
            a_size = bus.size;
            a_sext = bus.sign_ext;
            a_addr = bus.addr;
            a_wd   = bus.wd;
        end
    end

    // Request checks on the incoming request (only meaningful in IDLE).
    logic        bad_size;
    logic        misalign;
    logic        out_of_range;
    logic        in_err;
    logic [1:0]  nbytes_m1;
    logic [32:0] last_byte;

    always_comb begin
        bad_size = (bus.size == 2'b11);
        misalign = ((bus.size == 2'b01) && bus.addr[0]) ||
                   ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
        case (bus.size)
            2'b00:   nbytes_m1 = 2'd0;
            2'b01:   nbytes_m1 = 2'd1;
            default: nbytes_m1 = 2'd3;
        endcase
        // 33-bit sum so an address near 2^32 cannot wrap into range.
        last_byte    = {1'b0, bus.addr} + 33'(nbytes_m1);
        out_of_range = (last_byte >= 33'(DEPTH_BYTES));
        in_err       = bad_size || misalign || out_of_range;
    end

    // Memory organised as four byte lanes sharing one row index. Legal
    // accesses are naturally aligned, so they never straddle a row.
    logic [RW-1:0]   row;
    logic [3:0]      lane_sel;
    logic [3:0]      lane_we;
    logic [31:0]     wdata_word;
    logic [3:0][7:0] lane_rdata;
    logic [31:0]     rword;
    logic [31:0]     rdata_ext;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;
    logic            unused_addr_bits;

    assign row              = a_addr[RW+1:2];
    assign unused_addr_bits = ^a_addr[31:RW+2];

    always_comb begin
        lane_sel   = 4'b0000;
        wdata_word = a_wd;
        case (a_size)
            2'b00: begin
                lane_sel[a_addr[1:0]] = 1'b1;
                wdata_word            = {4{a_wd[7:0]}};
            end
            2'b01: begin
                lane_sel   = a_addr[1] ? 4'b1100 : 4'b0011;
                wdata_word = {2{a_wd[15:0]}};
            end
            2'b10: begin
                lane_sel = 4'b1111;
            end
            default: begin
                lane_sel = 4'b0000;
            end
        endcase
        // rst gates the write so an access aborted by reset never lands.
        lane_we = (do_acc && a_we && !rst) ? lane_sel : 4'b0000;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [ROWS];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[row] <= wdata_word[8*gi +: 8];
                end
            end

            assign lane_rdata[gi] = lane_mem[row];
        end
    endgenerate

    assign rword = lane_rdata;

    always_comb begin
        case (a_addr[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = a_addr[1] ? rword[31:16] : rword[15:0];
        case (a_size)
            2'b00:   rdata_ext = a_sext ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
            2'b01:   rdata_ext = a_sext ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
            default: rdata_ext = rword;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        do_acc  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                err_d  = 1'b0;
                if (bus.req) begin
                    we_d   = bus.we;
                    size_d = bus.size;
                    sext_d = bus.sign_ext;
                    addr_d = bus.addr;
                    wd_d   = bus.wd;
                    busy_d = 1'b1;
                    if (in_err) begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (LAT_ZERO) begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        do_acc  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    do_acc  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b0;
            end
        endcase

        if (do_acc && !a_we) begin
            rd_d = rdata_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.rd    = rd_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_dmem_waitstate.sv
// Testbench for dmem_waitstate: one instance built with LATENCY=2 and one
// with LATENCY=0, driven by a directed sequence. Expected rd/err/latency are
// pushed to a scoreboard when a request is driven and popped on ready.
module tb_dmem_waitstate;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_waitstate_if bus2 ();
    dmem_waitstate_if bus0 ();

    dmem_waitstate #(.DEPTH_BYTES(1024), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    dmem_waitstate #(.DEPTH_BYTES(1024), .LATENCY(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic sample(input bit z, output logic [31:0] rd, output logic ready,
                          output logic busy, output logic err);
        if (z) begin
            rd = bus0.rd; ready = bus0.ready; busy = bus0.busy; err = bus0.err;
        end else begin
            rd = bus2.rd; ready = bus2.ready; busy = bus2.busy; err = bus2.err;
        end
    endtask

    task automatic drive(input bit z, input logic req, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] d);
        if (z) begin
            bus0.req = req; bus0.we = w; bus0.size = sz; bus0.sign_ext = sx;
            bus0.addr = a; bus0.wd = d;
        end else begin
            bus2.req = req; bus2.we = w; bus2.size = sz; bus2.sign_ext = sx;
            bus2.addr = a; bus2.wd = d;
        end
    endtask

    task automatic drop_req(input bit z);
        if (z) bus0.req = 1'b0;
        else   bus2.req = 1'b0;
    endtask

    // One access, called at a negedge with the DUT idle. hold keeps req high
    // until the ready pulse is observed.
    task automatic access(input string tag, input bit z, input bit hold, input logic w,
                          input logic [1:0] sz, input logic sx, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat);
        exp_t        e;
        logic [31:0] rd;
        logic        ready, busy, err;
        int          n;
        bit          got;
        e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat;
        sb.push_back(e);
        drive(z, 1'b1, w, sz, sx, a, d);
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (!hold) drop_req(z);
            sample(z, rd, ready, busy, err);
            if (ready === 1'b1) got = 1'b1;
            else chk({tag, ".busy_wait"}, 32'(busy), 32'd1);
        end
        drop_req(z);
        if (!got) begin
            chk({tag, ".timeout"}, 32'(n), 32'(exp_lat));
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({tag, ".lat"}, 32'(n), 32'(e.lat));
            chk({tag, ".rd"}, rd, e.rd);
            chk({tag, ".err"}, 32'(err), 32'(e.err));
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            $display("txn %s: z=%0d we=%0d size=%0d addr=0x%08h wd=0x%08h rd=0x%08h err=%0d lat=%0d",
                     tag, z, w, sz, a, d, rd, err, n);
        end
        @(negedge clk);
        sample(z, rd, ready, busy, err);
        chk({tag, ".ready_off"}, 32'(ready), 32'd0);
        chk({tag, ".busy_off"}, 32'(busy), 32'd0);
        chk({tag, ".err_off"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ready, busy, err;
        int          pulses;

        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int z = 0; z < 2; z++) begin
            sample(z[0], rd, ready, busy, err);
            chk("reset.rd", rd, 32'd0);
            chk("reset.ready", 32'(ready), 32'd0);
            chk("reset.busy", 32'(busy), 32'd0);
            chk("reset.err", 32'(err), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // LATENCY=2 instance: data path and extension
        access("wr_w10",    0, 0, 1, 2'b10, 0, 32'h10,  32'h8899AABB, 32'h00000000, 0, 3);
        access("rd_w10",    0, 0, 0, 2'b10, 0, 32'h10,  32'h0,        32'h8899AABB, 0, 3);
        access("wr_b11",    0, 0, 1, 2'b00, 0, 32'h11,  32'h00000080, 32'h8899AABB, 0, 3);
        access("rd_b11_s",  0, 0, 0, 2'b00, 1, 32'h11,  32'h0,        32'hFFFFFF80, 0, 3);
        access("rd_b11_z",  0, 0, 0, 2'b00, 0, 32'h11,  32'h0,        32'h00000080, 0, 3);
        access("rd_w10b",   0, 0, 0, 2'b10, 0, 32'h10,  32'h0,        32'h889980BB, 0, 3);
        access("rd_h12_s",  0, 0, 0, 2'b01, 1, 32'h12,  32'h0,        32'hFFFF8899, 0, 3);
        access("rd_h12_z",  0, 0, 0, 2'b01, 0, 32'h12,  32'h0,        32'h00008899, 0, 3);

        // Error responses: one cycle after accept, rd untouched
        access("err_h13",   0, 0, 0, 2'b01, 1, 32'h13,  32'h0,        32'h00008899, 1, 1);
        access("err_w3fe",  0, 0, 0, 2'b10, 0, 32'h3FE, 32'h0,        32'h00008899, 1, 1);
        access("wr_w00",    0, 0, 1, 2'b10, 0, 32'h0,   32'h01020304, 32'h00008899, 0, 3);
        access("err_w400",  0, 0, 1, 2'b10, 0, 32'h400, 32'hFFFFFFFF, 32'h00008899, 1, 1);
        access("rd_w00",    0, 0, 0, 2'b10, 0, 32'h0,   32'h0,        32'h01020304, 0, 3);
        access("err_sz11",  0, 0, 0, 2'b11, 0, 32'h0,   32'h0,        32'h01020304, 1, 1);
        access("wr_b3ff",   0, 0, 1, 2'b00, 0, 32'h3FF, 32'h000000A5, 32'h01020304, 0, 3);
        access("rd_b3ff",   0, 0, 0, 2'b00, 1, 32'h3FF, 32'h0,        32'hFFFFFFA5, 0, 3);

        // req held through WAIT/RESP: exactly one ready, nothing queued
        access("hold_rd",   0, 1, 0, 2'b10, 0, 32'h10,  32'h0,        32'h889980BB, 0, 3);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus2.ready === 1'b1) pulses++;
        end
        chk("hold.extra_ready", 32'(pulses), 32'd0);

        // Reset during WAIT aborts a write
        access("wr_w20",    0, 0, 1, 2'b10, 0, 32'h20,  32'h11223344, 32'h889980BB, 0, 3);
        drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        drop_req(1'b0);
        rst = 1'b1;
        @(negedge clk);
        sample(1'b0, rd, ready, busy, err);
        chk("rst_abort.ready", 32'(ready), 32'd0);
        chk("rst_abort.busy", 32'(busy), 32'd0);
        chk("rst_abort.rd", rd, 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus2.ready === 1'b1) pulses++;
        end
        chk("rst_abort.no_ready", 32'(pulses), 32'd0);
        $display("txn rst_abort: write 0xDEADBEEF @0x20 aborted in WAIT");
        access("rd_w20",    0, 0, 0, 2'b10, 0, 32'h20,  32'h0,        32'h11223344, 0, 3);

        // LATENCY=0 instance
        access("l0_wr_w40", 1, 0, 1, 2'b10, 0, 32'h40,  32'hCAFEF00D, 32'h00000000, 0, 1);
        access("l0_rd_w40", 1, 0, 0, 2'b10, 0, 32'h40,  32'h0,        32'hCAFEF00D, 0, 1);
        access("l0_err_41", 1, 0, 0, 2'b10, 0, 32'h41,  32'h0,        32'hCAFEF00D, 1, 1);

        // Back-to-back reads with req held: accepted every second cycle
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h43, 32'h0);
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            sample(1'b1, rd, ready, busy, err);
            chk($sformatf("b2b.ready%0d", n), 32'(ready), 32'(n % 2));
            chk($sformatf("b2b.busy%0d", n), 32'(busy), 32'(n % 2));
            if (n % 2 == 1) begin
                chk($sformatf("b2b.rd%0d", n), rd, 32'h000000CA);
                $display("txn b2b%0d: z=1 read byte @0x43 rd=0x%08h", n, rd);
            end
        end
        drop_req(1'b1);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
